// File: rtl/wb_arbiter.sv
// Writeback arbiter: one small completion FIFO per execution source feeding
// three class ports (scalar / fp / vector), each with its own round-robin arbiter.
module wb_arbiter #(
  parameter int DATA_W     = 32,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [3:0]          src_valid,
  output logic [3:0]          src_ready,
  input  logic [7:0]          src_class,
  input  logic [19:0]         src_rd,
  input  logic [4*DATA_W-1:0] src_data,
  output logic                wb_scalar_valid,
  output logic [4:0]          wb_scalar_rd,
  output logic [DATA_W-1:0]   wb_scalar_data,
  output logic                wb_fp_valid,
  output logic [4:0]          wb_fp_rd,
  output logic [DATA_W-1:0]   wb_fp_data,
  output logic                wb_vec_valid,
  output logic [4:0]          wb_vec_rd,
  output logic [DATA_W-1:0]   wb_vec_data,
  output logic                idle
);
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  typedef struct packed {
    logic [1:0]        cls;
    logic [4:0]        rd;
    logic [DATA_W-1:0] data;
  } entry_t;

  entry_t            mem    [4][FIFO_DEPTH];
  logic [PW-1:0]     wr_ptr [4];
  logic [PW-1:0]     rd_ptr [4];
  logic [CW-1:0]     count  [4];
  entry_t            head   [4];
  logic [3:0]        push;
  logic [3:0]        pop;
  logic [3:0]        req    [3];
  logic [1:0]        rr_ptr [3];
  logic [1:0]        gidx   [3];
  logic [2:0]        gany;
  logic [2:0]        wb_valid;
  logic [4:0]        wb_rd   [3];
  logic [DATA_W-1:0] wb_data [3];

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // NOTE: combinational blocks use blocking '=' and assign every output a default first, so no latch is inferred.
  always_comb begin
    push = '0;
    for (int i = 0; i < 4; i++) begin
      src_ready[i] = !rst && (count[i] < CW'(FIFO_DEPTH));
      push[i]      = src_valid[i] && src_ready[i];
      head[i]      = mem[i][rd_ptr[i]];
    end
  end

  // Each non-empty head requests exactly one port; class 11 folds into vector.
  always_comb begin
    for (int c = 0; c < 3; c++) req[c] = '0;
    for (int i = 0; i < 4; i++) begin
      if (count[i] != '0) begin
        if (head[i].cls[1])      req[2][i] = 1'b1;
        else if (head[i].cls[0]) req[1][i] = 1'b1;
        else                     req[0][i] = 1'b1;
      end
    end
  end

  always_comb begin
    logic       found;
    logic [1:0] idx;
    found = 1'b0;
    idx   = '0;
    pop   = '0;
    gany  = '0;
    for (int c = 0; c < 3; c++) begin
      gidx[c] = '0;
      found   = 1'b0;
      for (int k = 0; k < 4; k++) begin
        idx = rr_ptr[c] + 2'(k);
        if (!found && req[c][idx]) begin
          found   = 1'b1;
          gidx[c] = idx;
          pop[idx] = 1'b1;
        end
      end
      gany[c] = found;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) begin
        wr_ptr[i] <= '0;
        rd_ptr[i] <= '0;
        count[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (push[i]) wr_ptr[i] <= ptr_inc(wr_ptr[i]);
        if (pop[i])  rd_ptr[i] <= ptr_inc(rd_ptr[i]);
        count[i] <= count[i] + CW'(push[i]) - CW'(pop[i]);
      end
    end
  end

  // NOTE: FIFO storage has no reset; count gates every read, so stale words are never observed.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (push[i]) begin
        mem[i][wr_ptr[i]] <= '{cls:  src_class[2*i +: 2],
                               rd:   src_rd[5*i +: 5],
                               data: src_data[DATA_W*i +: DATA_W]};
      end
    end
  end

  // Ports: valid pulses for one cycle per grant; rd/data hold between grants.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_valid <= '0;
      for (int c = 0; c < 3; c++) begin
        rr_ptr[c]  <= '0;
        wb_rd[c]   <= '0;
        wb_data[c] <= '0;
      end
    end else begin
      wb_valid <= gany;
      for (int c = 0; c < 3; c++) begin
        if (gany[c]) begin
          rr_ptr[c]  <= gidx[c] + 2'd1;
          wb_rd[c]   <= head[gidx[c]].rd;
          wb_data[c] <= head[gidx[c]].data;
        end
      end
    end
  end

  always_comb begin
    idle = (wb_valid == '0);
    for (int i = 0; i < 4; i++) begin
      if (count[i] != '0) idle = 1'b0;
    end
  end

  assign wb_scalar_valid = wb_valid[0];
  assign wb_scalar_rd    = wb_rd[0];
  assign wb_scalar_data  = wb_data[0];
  assign wb_fp_valid     = wb_valid[1];
  assign wb_fp_rd        = wb_rd[1];
  assign wb_fp_data      = wb_data[1];
  assign wb_vec_valid    = wb_valid[2];
  assign wb_vec_rd       = wb_rd[2];
  assign wb_vec_data     = wb_data[2];
endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter: queue-based reference model compared every cycle,
// plus directed scenarios with hand-computed literal expectations.
`timescale 1ns/1ps
module tb_wb_arbiter;
  localparam int DW    = 32;
  localparam int DEPTH = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [3:0]    src_valid = '0;
  logic [3:0]    src_ready;
  logic [7:0]    src_class = '0;
  logic [19:0]   src_rd = '0;
  logic [4*DW-1:0] src_data = '0;
  logic          wb_scalar_valid, wb_fp_valid, wb_vec_valid;
  logic [4:0]    wb_scalar_rd, wb_fp_rd, wb_vec_rd;
  logic [DW-1:0] wb_scalar_data, wb_fp_data, wb_vec_data;
  logic          idle;

  int n_vec  = 0;
  int n_miss = 0;

  always #5 clk = ~clk;

  wb_arbiter #(.DATA_W(DW), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .src_valid(src_valid), .src_ready(src_ready),
    .src_class(src_class), .src_rd(src_rd), .src_data(src_data),
    .wb_scalar_valid(wb_scalar_valid), .wb_scalar_rd(wb_scalar_rd), .wb_scalar_data(wb_scalar_data),
    .wb_fp_valid(wb_fp_valid), .wb_fp_rd(wb_fp_rd), .wb_fp_data(wb_fp_data),
    .wb_vec_valid(wb_vec_valid), .wb_vec_rd(wb_vec_rd), .wb_vec_data(wb_vec_data),
    .idle(idle)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp_v);
    n_vec++;
    if (act !== exp_v) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp_v, $time);
    end
  endtask

  // Reference model: per-source queues, per-class "next source to favour".
  typedef struct {
    logic [1:0]    cls;
    logic [4:0]    rd;
    logic [DW-1:0] data;
  } ent_t;

  ent_t          q[4][$];
  int            rr[3];
  logic          m_valid[3];
  logic [4:0]    m_rd[3];
  logic [DW-1:0] m_data[3];
  int            n_accepted = 0;
  int            n_written  = 0;
  logic [7:0]    scalar_ids[$];
  bit            record_ids = 1'b0;

  function automatic int port_of(input logic [1:0] cls);
    return cls[1] ? 2 : (cls[0] ? 1 : 0);
  endfunction

  always @(posedge clk or posedge rst) begin : model
    bit   acc[4];
    bit   taken[4];
    int   s;
    int   win;
    ent_t e;
    if (rst) begin
      for (int i = 0; i < 4; i++) q[i].delete();
      for (int c = 0; c < 3; c++) begin
        rr[c] = 0; m_valid[c] = 1'b0; m_rd[c] = '0; m_data[c] = '0;
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        acc[i]   = src_valid[i] && (q[i].size() < DEPTH);
        taken[i] = 1'b0;
      end
      for (int c = 0; c < 3; c++) begin
        win = -1;
        for (int k = 0; k < 4; k++) begin
          s = (rr[c] + k) % 4;
          if (win < 0 && q[s].size() > 0 && port_of(q[s][0].cls) == c) win = s;
        end
        m_valid[c] = (win >= 0);
        if (win >= 0) begin
          m_rd[c]    = q[win][0].rd;
          m_data[c]  = q[win][0].data;
          taken[win] = 1'b1;
          rr[c]      = (win + 1) % 4;
        end
      end
      for (int i = 0; i < 4; i++) begin
        if (taken[i]) void'(q[i].pop_front());
        if (acc[i]) begin
          e.cls  = src_class[2*i +: 2];
          e.rd   = src_rd[5*i +: 5];
          e.data = src_data[DW*i +: DW];
          q[i].push_back(e);
          n_accepted++;
        end
      end
    end
  end

  always @(negedge clk) begin : compare
    logic [3:0] exp_ready;
    logic       exp_idle;
    exp_idle = !(m_valid[0] || m_valid[1] || m_valid[2]);
    for (int i = 0; i < 4; i++) begin
      exp_ready[i] = !rst && (q[i].size() < DEPTH);
      if (q[i].size() != 0) exp_idle = 1'b0;
    end
    check("src_ready",       64'(src_ready),       64'(exp_ready));
    check("wb_scalar_valid", 64'(wb_scalar_valid), 64'(m_valid[0]));
    check("wb_scalar_rd",    64'(wb_scalar_rd),    64'(m_rd[0]));
    check("wb_scalar_data",  64'(wb_scalar_data),  64'(m_data[0]));
    check("wb_fp_valid",     64'(wb_fp_valid),     64'(m_valid[1]));
    check("wb_fp_rd",        64'(wb_fp_rd),        64'(m_rd[1]));
    check("wb_fp_data",      64'(wb_fp_data),      64'(m_data[1]));
    check("wb_vec_valid",    64'(wb_vec_valid),    64'(m_valid[2]));
    check("wb_vec_rd",       64'(wb_vec_rd),       64'(m_rd[2]));
    check("wb_vec_data",     64'(wb_vec_data),     64'(m_data[2]));
    check("idle",            64'(idle),            64'(exp_idle));
    n_written += int'(wb_scalar_valid) + int'(wb_fp_valid) + int'(wb_vec_valid);
    if (record_ids && wb_scalar_valid) scalar_ids.push_back(wb_scalar_data[DW-1 -: 8]);
  end

  task automatic set_src(input int i, input logic [1:0] c, input logic [4:0] r, input logic [DW-1:0] d);
    src_valid[i]         = 1'b1;
    src_class[2*i +: 2]  = c;
    src_rd[5*i +: 5]     = r;
    src_data[DW*i +: DW] = d;
  endtask

  task automatic wait_idle(input int budget);
    int k = 0;
    while (idle !== 1'b1 && k < budget) begin
      @(negedge clk);
      k++;
    end
    check("drain_to_idle", 64'(idle), 64'h1);
  endtask

  task automatic pulse_reset();
    #1 rst = 1'b1;
    @(negedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
  endtask

  // Scalar traffic with a proper handshake: a source's word only advances once accepted.
  int         seq[4];
  logic [3:0] seen_low;
  logic [3:0] seen_rise;

  task automatic run_traffic(input logic [3:0] mask, input int cycles);
    logic [3:0] acc;
    seen_low  = '0;
    seen_rise = '0;
    for (int i = 0; i < 4; i++) seq[i] = 0;
    for (int t = 0; t < cycles; t++) begin
      #1;
      src_valid = '0;
      for (int i = 0; i < 4; i++) begin
        if (mask[i]) set_src(i, 2'b00, 5'(seq[i]), {8'(i), 24'(seq[i])});
      end
      acc = src_valid & src_ready;
      for (int i = 0; i < 4; i++) begin
        if (mask[i] && !src_ready[i]) seen_low[i] = 1'b1;
        else if (mask[i] && seen_low[i]) seen_rise[i] = 1'b1;
      end
      @(negedge clk);
      for (int i = 0; i < 4; i++) if (acc[i]) seq[i]++;
    end
    #1 src_valid = '0;
    @(negedge clk);
  endtask

  initial begin
    int per_src[4];

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_ready_low", 64'(src_ready), 64'h0);
    check("rst_idle", 64'(idle), 64'h1);
    check("rst_scalar_valid", 64'(wb_scalar_valid), 64'h0);
    #1 rst = 1'b0;
    @(negedge clk);
    check("post_rst_ready", 64'(src_ready), 64'hF);

    // Single ALU completion: output exactly two edges after the handshake
    #1 set_src(0, 2'b00, 5'd5, 32'hDEADBEEF);
    @(negedge clk);
    #1 src_valid = '0;
    check("single_not_early", 64'(wb_scalar_valid), 64'h0);
    @(negedge clk);
    check("single_valid", 64'(wb_scalar_valid), 64'h1);
    check("single_rd", 64'(wb_scalar_rd), 64'd5);
    check("single_data", 64'(wb_scalar_data), 64'hDEADBEEF);
    @(negedge clk);
    check("single_one_cycle", 64'(wb_scalar_valid), 64'h0);
    check("single_idle_after", 64'(idle), 64'h1);
    check("single_rd_held", 64'(wb_scalar_rd), 64'd5);

    // Three classes in one cycle, class 11 routes to vector
    #1;
    set_src(0, 2'b00, 5'd1, 32'h0000_0011);
    set_src(1, 2'b01, 5'd2, 32'h0000_0022);
    set_src(3, 2'b11, 5'd3, 32'h0000_0033);
    @(negedge clk);
    #1 src_valid = '0;
    @(negedge clk);
    check("tri_scalar_valid", 64'(wb_scalar_valid), 64'h1);
    check("tri_fp_valid", 64'(wb_fp_valid), 64'h1);
    check("tri_vec_valid", 64'(wb_vec_valid), 64'h1);
    check("tri_scalar_rd", 64'(wb_scalar_rd), 64'd1);
    check("tri_fp_rd", 64'(wb_fp_rd), 64'd2);
    check("tri_vec_rd", 64'(wb_vec_rd), 64'd3);
    check("tri_vec_data", 64'(wb_vec_data), 64'h33);
    wait_idle(10);

    // All four sources scalar for 40 cycles from fresh RR pointers
    pulse_reset();
    record_ids = 1'b1;
    run_traffic(4'b1111, 40);
    wait_idle(40);
    record_ids = 1'b0;
    check("rr_stream_len_ge8", 64'(scalar_ids.size() >= 8), 64'h1);
    if (scalar_ids.size() >= 8) begin
      for (int k = 0; k < 8; k++) check("rr_order", 64'(scalar_ids[k]), 64'(k % 4));
    end
    for (int i = 0; i < 4; i++) per_src[i] = 0;
    foreach (scalar_ids[k]) if (scalar_ids[k] < 4) per_src[scalar_ids[k]]++;
    for (int i = 0; i < 4; i++) check("per_src_wb_count", 64'(per_src[i]), 64'(seq[i]));
    check("all_ready_dropped", 64'(seen_low), 64'hF);

    // LSU backpressure against a busy scalar port
    run_traffic(4'b0111, 16);
    wait_idle(20);
    check("lsu_ready_dropped", 64'(seen_low[2]), 64'h1);
    check("lsu_ready_recovered", 64'(seen_rise[2]), 64'h1);

    // Reset with three entries buffered
    #1;
    set_src(0, 2'b00, 5'd7, 32'h7);
    set_src(1, 2'b00, 5'd8, 32'h8);
    set_src(2, 2'b00, 5'd9, 32'h9);
    @(negedge clk);
    check("buffered_not_idle", 64'(idle), 64'h0);
    #1;
    src_valid = '0;
    rst = 1'b1;
    @(negedge clk);
    check("midrst_ready_low", 64'(src_ready), 64'h0);
    check("midrst_idle", 64'(idle), 64'h1);
    #1 rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("postrst_no_wb", 64'({wb_scalar_valid, wb_fp_valid, wb_vec_valid}), 64'h0);
      check("postrst_ready", 64'(src_ready), 64'hF);
    end

    // Random mixed-class traffic; every cycle compared against the model
    n_accepted = 0;
    n_written  = 0;
    for (int t = 0; t < 300; t++) begin
      #1;
      src_valid = 4'($urandom);
      src_class = 8'($urandom);
      src_rd    = 20'($urandom);
      src_data  = {$urandom, $urandom, $urandom, $urandom};
      @(negedge clk);
    end
    #1 src_valid = '0;
    @(negedge clk);
    wait_idle(60);
    check("random_accept_eq_written", 64'(n_written), 64'(n_accepted));
    check("random_some_traffic", 64'(n_accepted > 100), 64'h1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: bench did not finish, elapsed %0t, limit 500000", $time);
    $fatal(1);
  end
endmodule
